// File: rtl/psum_bank_buffer_pkg.sv
// Shared types, default parameters and the lane saturation helper for the
// partial-sum bank buffer.
package psum_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DEPTH_DEF  = 16;
  localparam int DATA_W_DEF = 24;
  localparam bit SAT_EN_DEF = 1'b1;

  // Working width of sat_add; any lane width below this is supported.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } psum_state_e;

  // Operands arrive sign-extended from a w-bit lane. Returns {ovf, result};
  // the caller keeps the low w bits of result, which is the wrapped value
  // when sat_en is 0 and the clamped value when sat_en is 1.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input bit                          sat_en,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] sum;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    logic signed [SAT_MAX_W-1:0] res;
    logic                        ovf;
    sum = a + b;
    hi  = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
    lo  = -hi - SAT_MAX_W'(1);
    ovf = (sum > hi) || (sum < lo);
    res = sum;
    if (sat_en && (sum > hi)) begin
      res = hi;
    end else if (sat_en && (sum < lo)) begin
      res = lo;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/psum_bank_buffer_if.sv
// Bus bundle between the PE accumulators / writeback path and the bank buffer.
interface psum_bank_buffer_if
  import psum_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int SEL_W = $clog2(DEPTH);
  localparam int ROW_W = NUM_CH * DATA_W;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a presented payload holds
  // until its transfer.
  logic              acc_val_i;
  logic              acc_rdy_o;
  logic [SEL_W-1:0]  acc_sel_i;
  logic              acc_mode_i;
  logic [ROW_W-1:0]  acc_dat_i;
  logic [ROW_W-1:0]  acc_dat_o;

  logic              drain_start_i;
  logic              drain_clr_i;
  logic              out_val_o;
  logic              out_rdy_i;
  logic [SEL_W-1:0]  out_idx_o;
  logic [ROW_W-1:0]  out_dat_o;
  logic              out_last_o;

  logic              busy_o;
  logic [NUM_CH-1:0] ovf_o;
  psum_state_e       dbg_state;

  modport slave (
    input  acc_val_i, acc_sel_i, acc_mode_i, acc_dat_i,
    input  drain_start_i, drain_clr_i, out_rdy_i,
    output acc_rdy_o, acc_dat_o, out_val_o, out_idx_o, out_dat_o, out_last_o,
    output busy_o, ovf_o, dbg_state
  );

  modport master (
    output acc_val_i, acc_sel_i, acc_mode_i, acc_dat_i,
    output drain_start_i, drain_clr_i, out_rdy_i,
    input  acc_rdy_o, acc_dat_o, out_val_o, out_idx_o, out_dat_o, out_last_o,
    input  busy_o, ovf_o, dbg_state
  );

endinterface

// File: rtl/psum_bank_buffer_lane_alu.sv
// One accumulate lane: overwrite mux, add, and saturate-or-wrap.
module psum_lane_alu
  import psum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit SAT_EN = SAT_EN_DEF
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] din,
  input  logic              mode,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);

  logic signed [SAT_MAX_W-1:0] cur_ext;
  logic signed [SAT_MAX_W-1:0] din_ext;
  logic        [SAT_MAX_W:0]   add_r;

  always_comb begin
    cur_ext = SAT_MAX_W'($signed(cur));
    din_ext = SAT_MAX_W'($signed(din));
    add_r   = sat_add(cur_ext, din_ext, SAT_EN, DATA_W);
    if (mode) begin
      res = DATA_W'(add_r[SAT_MAX_W-1:0]);
      ovf = add_r[SAT_MAX_W];
    end else begin
      res = din;
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/psum_bank_buffer.sv
// Multi-lane partial-sum bank: read-modify-write accumulate with saturation,
// sticky overflow flags, and a drain sequencer with optional clear-on-read.
module psum_bank_buffer
  import psum_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit SAT_EN = SAT_EN_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  psum_bank_buffer_if.slave  bus
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam int ROW_W = NUM_CH * DATA_W;

  logic [ROW_W-1:0]  mem [DEPTH];

  psum_state_e       state_q;
  psum_state_e       state_nxt;

  logic              acc_rdy;
  logic              busy;
  logic              accept;
  logic              start;
  logic              hs;

  logic              out_val_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  out_idx_q;
  logic [SEL_W-1:0]  nxt_idx;
  logic [ROW_W-1:0]  out_dat_q;
  logic              clr_q;
  logic [NUM_CH-1:0] ovf_q;

  logic [ROW_W-1:0]  cur_row;
  logic [ROW_W-1:0]  alu_row;
  logic [NUM_CH-1:0] alu_ovf;

  assign cur_row = mem[bus.acc_sel_i];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    psum_lane_alu #(
      .DATA_W (DATA_W),
      .SAT_EN (SAT_EN)
    ) u_alu (
      .cur  (cur_row[k*DATA_W +: DATA_W]),
      .din  (bus.acc_dat_i[k*DATA_W +: DATA_W]),
      .mode (bus.acc_mode_i),
      .res  (alu_row[k*DATA_W +: DATA_W]),
      .ovf  (alu_ovf[k])
    );
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (bus.drain_start_i) state_nxt = ST_DRAIN;
      ST_DRAIN: if (hs && out_last_q)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    acc_rdy = (state_q == ST_IDLE);
    busy    = (state_q != ST_IDLE);
    start   = (state_q == ST_IDLE) && bus.drain_start_i;
  end

  assign accept  = bus.acc_val_i && acc_rdy;
  assign hs      = out_val_q && bus.out_rdy_i;
  assign nxt_idx = out_idx_q + SEL_W'(1);

  // Accepts only happen in IDLE and clears only in DRAIN, so the two
  // write ports never collide.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      if (accept) begin
        mem[bus.acc_sel_i] <= alu_row;
      end
      if (hs && clr_q) begin
        mem[out_idx_q] <= '0;
      end
    end
  end

  // Drain output register. A write accepted alongside the start is forwarded
  // so entry 0 is presented with its new value.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_idx_q  <= '0;
      out_dat_q  <= '0;
      clr_q      <= 1'b0;
    end else if (start) begin
      out_val_q  <= 1'b1;
      out_last_q <= 1'b0;
      out_idx_q  <= '0;
      out_dat_q  <= (accept && (bus.acc_sel_i == '0)) ? alu_row : mem[0];
      clr_q      <= bus.drain_clr_i;
    end else if (hs) begin
      if (out_last_q) begin
        out_val_q  <= 1'b0;
        out_last_q <= 1'b0;
        out_idx_q  <= '0;
        out_dat_q  <= '0;
      end else begin
        out_idx_q  <= nxt_idx;
        out_dat_q  <= mem[nxt_idx];
        out_last_q <= (nxt_idx == SEL_W'(DEPTH - 1));
      end
    end
  end

  // Sticky overflow; a drain start clears it and takes priority.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ovf_q <= '0;
    end else if (start) begin
      ovf_q <= '0;
    end else if (accept) begin
      ovf_q <= ovf_q | alu_ovf;
    end
  end

  assign bus.acc_rdy_o  = acc_rdy;
  assign bus.acc_dat_o  = cur_row;
  assign bus.out_val_o  = out_val_q;
  assign bus.out_idx_o  = out_idx_q;
  assign bus.out_dat_o  = out_dat_q;
  assign bus.out_last_o = out_last_q;
  assign bus.busy_o     = busy;
  assign bus.ovf_o      = ovf_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_psum_bank_buffer.sv
// Directed bench for psum_bank_buffer: drained entries are checked by a
// negedge monitor against an expected queue filled by the stimulus.
module tb_psum_bank_buffer;
  import psum_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam bit SAT_EN = 1'b1;
  localparam int SEL_W  = $clog2(DEPTH);
  localparam int ROW_W  = NUM_CH * DATA_W;
  localparam int EXP_W  = SEL_W + 1 + ROW_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  int cyc;

  logic [EXP_W-1:0] exp_q[$];
  logic [ROW_W-1:0] model [DEPTH];
  logic [EXP_W-1:0] mon_cur;
  logic [EXP_W-1:0] stall_snap;
  logic             stall_seen = 1'b0;

  psum_bank_buffer_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus_if ();

  psum_bank_buffer #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .SAT_EN (SAT_EN)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus_if.out_val_o) begin
      mon_cur = {bus_if.out_idx_o, bus_if.out_last_o, bus_if.out_dat_o};
      if (stall_seen) check("stall_hold", mon_cur, stall_snap);
      if (bus_if.out_rdy_i) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drain_unexpected: got %0h expected no transfer", mon_cur);
        end else begin
          check("drain_entry", mon_cur, exp_q.pop_front());
        end
      end
      stall_seen = !bus_if.out_rdy_i;
      stall_snap = mon_cur;
    end else begin
      stall_seen = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int sel, input logic mode, input logic [ROW_W-1:0] dat);
    bus_if.acc_val_i  = 1'b1;
    bus_if.acc_sel_i  = SEL_W'(sel);
    bus_if.acc_mode_i = mode;
    bus_if.acc_dat_i  = dat;
    tick();
    bus_if.acc_val_i  = 1'b0;
  endtask

  task automatic read_check(input string name, input int sel, input logic [ROW_W-1:0] exp);
    bus_if.acc_sel_i = SEL_W'(sel);
    #1;
    check(name, bus_if.acc_dat_o, exp);
  endtask

  task automatic push_drain(input int upto);
    for (int i = 0; i < upto; i++) begin
      exp_q.push_back({SEL_W'(i), (i == DEPTH - 1), model[i]});
    end
  endtask

  initial begin
    bus_if.acc_val_i     = 1'b0;
    bus_if.acc_sel_i     = '0;
    bus_if.acc_mode_i    = 1'b0;
    bus_if.acc_dat_i     = '0;
    bus_if.drain_start_i = 1'b0;
    bus_if.drain_clr_i   = 1'b0;
    bus_if.out_rdy_i     = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_acc_rdy", bus_if.acc_rdy_o, 1);
    check("rst_out_val", bus_if.out_val_o, 0);
    check("rst_out_last", bus_if.out_last_o, 0);
    check("rst_busy", bus_if.busy_o, 0);
    check("rst_out_idx", bus_if.out_idx_o, 0);
    check("rst_out_dat", bus_if.out_dat_o, 0);
    check("rst_ovf", bus_if.ovf_o, 0);
    check("rst_state", bus_if.dbg_state, ST_IDLE);
    for (int e = 0; e < DEPTH; e++) read_check("rst_entry", e, '0);
    rst_n = 1'b1;
    tick();

    // overwrite then accumulate, including back-to-back accumulates
    write_entry(3, 1'b0, {16'hFFF0, 16'h0010});
    read_check("ow_entry3", 3, {16'hFFF0, 16'h0010});
    write_entry(3, 1'b1, {16'h0020, 16'h0005});
    read_check("acc_entry3", 3, {16'h0010, 16'h0015});
    check("acc_ovf", bus_if.ovf_o, 0);
    bus_if.acc_val_i  = 1'b1;
    bus_if.acc_sel_i  = 3'd3;
    bus_if.acc_mode_i = 1'b1;
    bus_if.acc_dat_i  = {16'h0001, 16'hFFFF};
    tick();
    tick();
    bus_if.acc_val_i  = 1'b0;
    read_check("b2b_entry3", 3, {16'h0012, 16'h0013});
    check("b2b_ovf", bus_if.ovf_o, 0);

    // saturation at both rails
    write_entry(5, 1'b0, {16'h8005, 16'h7FF0});
    write_entry(5, 1'b1, {16'hFFF0, 16'h0020});
    read_check("sat_entry5", 5, {16'h8000, 16'h7FFF});
    check("sat_ovf", bus_if.ovf_o, 2'b11);
    read_check("sat_entry3_kept", 3, {16'h0012, 16'h0013});

    // drain with alternating backpressure, no clear
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = {16'(-i), 16'(i)};
      write_entry(i, 1'b0, model[i]);
    end
    push_drain(DEPTH);
    hs_count = 0;
    bus_if.out_rdy_i     = 1'b1;
    bus_if.drain_start_i = 1'b1;
    bus_if.drain_clr_i   = 1'b0;
    tick();
    bus_if.drain_start_i = 1'b0;
    check("bp_busy", bus_if.busy_o, 1);
    check("bp_ovf_cleared", bus_if.ovf_o, 0);
    check("bp_acc_rdy", bus_if.acc_rdy_o, 0);
    cyc = 0;
    while (bus_if.busy_o && cyc < 64) begin
      tick();
      cyc++;
      bus_if.out_rdy_i = !bus_if.out_rdy_i;
    end
    bus_if.out_rdy_i = 1'b0;
    check("bp_finished", bus_if.busy_o, 0);
    check("bp_hs_count", hs_count, DEPTH);
    check("bp_queue_left", exp_q.size(), 0);
    for (int i = 0; i < DEPTH; i++) read_check("bp_entry_kept", i, model[i]);

    // clear-on-read, write in the start cycle, lockout mid-drain
    write_entry(5, 1'b1, {16'h0000, 16'h7FFF});
    model[5] = {16'hFFFB, 16'h7FFF};
    read_check("pre_clr_entry5", 5, model[5]);
    check("pre_clr_ovf", bus_if.ovf_o, 2'b01);
    model[0] = {16'hAAAA, 16'h5555};
    push_drain(DEPTH);
    hs_count = 0;
    bus_if.out_rdy_i     = 1'b1;
    bus_if.acc_val_i     = 1'b1;
    bus_if.acc_sel_i     = '0;
    bus_if.acc_mode_i    = 1'b0;
    bus_if.acc_dat_i     = model[0];
    bus_if.drain_start_i = 1'b1;
    bus_if.drain_clr_i   = 1'b1;
    tick();
    bus_if.acc_val_i     = 1'b0;
    bus_if.drain_start_i = 1'b0;
    bus_if.drain_clr_i   = 1'b0;
    check("clr_ovf_cleared", bus_if.ovf_o, 0);
    check("clr_busy", bus_if.busy_o, 1);
    cyc = 1;
    while (bus_if.busy_o && cyc < 64) begin
      if (cyc == 3) begin
        bus_if.acc_val_i  = 1'b1;
        bus_if.acc_sel_i  = 3'd2;
        bus_if.acc_mode_i = 1'b0;
        bus_if.acc_dat_i  = 32'h1234_1234;
        #1;
        check("lock_acc_rdy", bus_if.acc_rdy_o, 0);
      end
      tick();
      bus_if.acc_val_i = 1'b0;
      cyc++;
    end
    // start edge plus DEPTH transfers plus DONE before IDLE
    check("clr_cycles_to_idle", cyc, DEPTH + 2);
    check("clr_acc_rdy_back", bus_if.acc_rdy_o, 1);
    check("clr_hs_count", hs_count, DEPTH);
    check("clr_queue_left", exp_q.size(), 0);
    bus_if.out_rdy_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      read_check("clr_entry_zero", i, model[i]);
    end

    // reset in the middle of a drain
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = {16'(i * 3 + 1), 16'(100 + i)};
      write_entry(i, 1'b0, model[i]);
    end
    push_drain(4);
    hs_count = 0;
    bus_if.out_rdy_i     = 1'b1;
    bus_if.drain_start_i = 1'b1;
    tick();
    bus_if.drain_start_i = 1'b0;
    cyc = 0;
    while (bus_if.out_idx_o != 3'd4 && cyc < 32) begin
      tick();
      cyc++;
    end
    check("rd_reached_idx4", bus_if.out_idx_o, 4);
    rst_n = 1'b0;
    bus_if.out_rdy_i = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rd_out_val", bus_if.out_val_o, 0);
    check("rd_busy", bus_if.busy_o, 0);
    check("rd_out_last", bus_if.out_last_o, 0);
    check("rd_out_idx", bus_if.out_idx_o, 0);
    check("rd_out_dat", bus_if.out_dat_o, 0);
    check("rd_acc_rdy", bus_if.acc_rdy_o, 1);
    check("rd_hs_count", hs_count, 4);
    check("rd_queue_left", exp_q.size(), 0);
    for (int i = 0; i < DEPTH; i++) read_check("rd_entry_zero", i, '0);
    tick();
    check("rd_no_output", bus_if.out_val_o, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
